// File: rtl/i2s_frame_mixer_pkg.sv
// Shared constants, FSM encodings and sample-format helpers for the I2S mixer
// path. Helpers work on 32-bit containers so any DAC width up to 29 bits fits.
package i2s_pkg;

    localparam int unsigned DEF_DAC_WIDTH = 16;
    localparam logic [DEF_DAC_WIDTH-1:0] MIDSCALE = 16'h8000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GRAB = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_SAT  = 2'd3;

    // Offset-binary to two's complement: u - 2^(w-1) equals the MSB flip, sign-extended.
    function automatic logic signed [31:0] ob_to_signed(input logic [31:0] u,
                                                        input int unsigned w);
        return $signed(u) - (32'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [31:0] signed_to_ob(input logic signed [31:0] v,
                                                 input int unsigned w);
        return $unsigned(v + (32'sd1 <<< (w - 1)));
    endfunction

endpackage

// File: rtl/i2s_strobe_sync.sv
// Two-flop synchroniser for the asynchronous lrck/frame strobe, followed by a
// rising-edge detector producing a single-cycle tick.
module i2s_strobe_sync (
    input  logic clk,
    input  logic arst,
    input  logic strobe_i,
    output logic tick_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], strobe_i};
        end
    end

    assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/i2s_frame_mixer.sv
// Per-frame source scheduler and mixer in front of the PCM5102 transmitter:
// grabs one stereo pair per enabled source, attenuates, sums, saturates.
module i2s_frame_mixer
    import i2s_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DAC_WIDTH = 16,
    parameter int ATT_BITS  = 2
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          frame_strobe,
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic [NUM_SRC*ATT_BITS-1:0]   src_att,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*DAC_WIDTH-1:0]  src_left,
    input  logic [NUM_SRC*DAC_WIDTH-1:0]  src_right,
    input  logic                          underrun_clr,
    output logic [DAC_WIDTH-1:0]          left,
    output logic [DAC_WIDTH-1:0]          right,
    output logic [NUM_SRC-1:0]            underrun,
    output logic                          overrun,
    output logic                          busy
);

    localparam int AW = DAC_WIDTH + $clog2(NUM_SRC) + 1;
    localparam int KW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [DAC_WIDTH-1:0] MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    logic                 tick;
    logic [1:0]           state_q, state_d;
    logic [KW-1:0]        k_q;
    logic signed [AW-1:0] acc_l_q, acc_r_q;
    logic signed [AW-1:0] add_l, add_r;
    logic [DAC_WIDTH-1:0] hold_l_q [NUM_SRC];
    logic [DAC_WIDTH-1:0] hold_r_q [NUM_SRC];
    logic [ATT_BITS-1:0]  att_q    [NUM_SRC];
    logic [NUM_SRC-1:0]   underrun_q;
    logic                 overrun_q;
    logic [DAC_WIDTH-1:0] left_q, right_q;

    i2s_strobe_sync u_sync (
        .clk      (clk),
        .arst     (arst),
        .strobe_i (frame_strobe),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tick) state_d = ST_GRAB;
            ST_GRAB: state_d = ST_ACC;
            ST_ACC:  if (k_q == KW'(NUM_SRC - 1)) state_d = ST_SAT;
            ST_SAT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign src_ready = (state_q == ST_GRAB) ? (src_en & src_valid) : '0;

    // Non-ready sources hold midscale, which converts to a zero contribution.
    assign add_l = AW'(ob_to_signed(32'(hold_l_q[k_q]), DAC_WIDTH) >>> att_q[k_q]);
    assign add_r = AW'(ob_to_signed(32'(hold_r_q[k_q]), DAC_WIDTH) >>> att_q[k_q]);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            underrun_q <= '0;
            overrun_q  <= 1'b0;
            left_q     <= MID;
            right_q    <= MID;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_l_q[i] <= MID;
                hold_r_q[i] <= MID;
                att_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (tick && state_q != ST_IDLE) overrun_q <= 1'b1;
            // A new underrun in the same cycle as a clear wins.
            underrun_q <= (underrun_clr ? '0 : underrun_q)
                        | ((state_q == ST_GRAB) ? (src_en & ~src_valid) : '0);
            case (state_q)
                ST_IDLE: begin
                    acc_l_q <= '0;
                    acc_r_q <= '0;
                    k_q     <= '0;
                end
                ST_GRAB: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        hold_l_q[i] <= src_ready[i] ? src_left[i*DAC_WIDTH +: DAC_WIDTH]  : MID;
                        hold_r_q[i] <= src_ready[i] ? src_right[i*DAC_WIDTH +: DAC_WIDTH] : MID;
                        att_q[i]    <= src_att[i*ATT_BITS +: ATT_BITS];
                    end
                end
                ST_ACC: begin
                    acc_l_q <= acc_l_q + add_l;
                    acc_r_q <= acc_r_q + add_r;
                    k_q     <= k_q + KW'(1);
                end
                ST_SAT: begin
                    left_q  <= DAC_WIDTH'(signed_to_ob(saturate(32'(acc_l_q), DAC_WIDTH), DAC_WIDTH));
                    right_q <= DAC_WIDTH'(signed_to_ob(saturate(32'(acc_r_q), DAC_WIDTH), DAC_WIDTH));
                end
                default: ;
            endcase
        end
    end

    assign left     = left_q;
    assign right    = right_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_frame_mixer.sv
// Directed bench for i2s_frame_mixer: mixing, saturation, attenuation,
// underrun/overrun flags, latency and mid-mix reset.
module tb_i2s_frame_mixer;

    logic        clk = 1'b0;
    logic        arst;
    logic        frame_strobe;
    logic [3:0]  src_en;
    logic [7:0]  src_att;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [63:0] src_left;
    logic [63:0] src_right;
    logic        underrun_clr;
    logic [15:0] left;
    logic [15:0] right;
    logic [3:0]  underrun;
    logic        overrun;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    i2s_frame_mixer #(.NUM_SRC(4), .DAC_WIDTH(16), .ATT_BITS(2)) dut (
        .clk          (clk),
        .arst         (arst),
        .frame_strobe (frame_strobe),
        .src_en       (src_en),
        .src_att      (src_att),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_left     (src_left),
        .src_right    (src_right),
        .underrun_clr (underrun_clr),
        .left         (left),
        .right        (right),
        .underrun     (underrun),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input bit en, input bit vld,
                           input logic [15:0] l, input logic [15:0] r, input logic [1:0] att);
        src_en[i]          = en;
        src_valid[i]       = vld;
        src_left[i*16 +: 16]  = l;
        src_right[i*16 +: 16] = r;
        src_att[i*2 +: 2]     = att;
    endtask

    // One full frame; observes src_ready at each negedge and can pulse
    // underrun_clr during the grab cycle.
    task automatic run_frame(input bit clr_in_grab, output logic [3:0] rdy_or, output int rdy_cyc);
        rdy_or  = '0;
        rdy_cyc = 0;
        @(negedge clk) frame_strobe = 1'b1;
        @(negedge clk) frame_strobe = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            underrun_clr = 1'b0;
            if (src_ready != 4'd0) begin
                rdy_or = rdy_or | src_ready;
                rdy_cyc++;
                if (clr_in_grab) underrun_clr = 1'b1;
            end
        end
        underrun_clr = 1'b0;
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    logic [3:0]  rdy;
    int          rcyc;
    logic [15:0] prev;
    int          upd;
    int          first_upd;
    bit          seen;

    initial begin
        arst = 1'b1; frame_strobe = 1'b0; underrun_clr = 1'b0;
        src_en = '0; src_valid = '0; src_att = '0; src_left = '0; src_right = '0;
        repeat (3) @(negedge clk);
        chk("rst_left",     32'(left),      32'h8000);
        chk("rst_right",    32'(right),     32'h8000);
        chk("rst_ready",    32'(src_ready), 32'h0);
        chk("rst_underrun", 32'(underrun),  32'h0);
        chk("rst_overrun",  32'(overrun),   32'h0);
        chk("rst_busy",     32'(busy),      32'h0);
        arst = 1'b0;
        repeat (2) @(negedge clk);

        // Single source
        set_src(0, 1, 1, 16'hC000, 16'h4000, 2'd0);
        run_frame(0, rdy, rcyc);
        chk("single_left",    32'(left),  32'hC000);
        chk("single_right",   32'(right), 32'h4000);
        chk("single_ready",   32'(rdy),   32'h1);
        chk("single_rdy_cyc", 32'(rcyc),  32'd1);

        // Saturation: left sums to +0x8000 -> clamps high, right to -0x10000 -> clamps low
        set_src(0, 1, 1, 16'hC000, 16'h0000, 2'd0);
        set_src(1, 1, 1, 16'hC000, 16'h0000, 2'd0);
        run_frame(0, rdy, rcyc);
        chk("sat_pos_left",  32'(left),  32'hFFFF);
        chk("sat_neg_right", 32'(right), 32'h0000);
        chk("sat_ready",     32'(rdy),   32'h3);

        // Attenuation
        set_src(0, 1, 1, 16'hC000, 16'h4000, 2'd1);
        set_src(1, 0, 0, 16'h0000, 16'h0000, 2'd0);
        run_frame(0, rdy, rcyc);
        chk("att_left",  32'(left),  32'hA000);
        chk("att_right", 32'(right), 32'h6000);
        set_src(1, 1, 1, 16'h2000, 16'h8000, 2'd0);
        run_frame(0, rdy, rcyc);
        chk("att2_left",  32'(left),  32'h4000);
        chk("att2_right", 32'(right), 32'h6000);

        // Underrun on src2, disabled-but-valid src3 must be ignored
        set_src(0, 1, 1, 16'hC000, 16'h4000, 2'd0);
        set_src(1, 0, 0, 16'h0000, 16'h0000, 2'd0);
        set_src(2, 1, 0, 16'hFFFF, 16'hFFFF, 2'd0);
        set_src(3, 0, 1, 16'hFFFF, 16'hFFFF, 2'd0);
        run_frame(0, rdy, rcyc);
        chk("ur_flag",  32'(underrun), 32'h4);
        chk("ur_left",  32'(left),     32'hC000);
        chk("ur_right", 32'(right),    32'h4000);
        chk("ur_ready", 32'(rdy),      32'h1);
        @(negedge clk) underrun_clr = 1'b1;
        @(negedge clk) underrun_clr = 1'b0;
        chk("ur_clr", 32'(underrun), 32'h0);
        run_frame(1, rdy, rcyc);
        chk("ur_set_wins", 32'(underrun), 32'h4);

        // Overrun and latency: two rising edges two clocks apart
        set_src(2, 0, 0, 16'h0000, 16'h0000, 2'd0);
        set_src(3, 0, 0, 16'h0000, 16'h0000, 2'd0);
        set_src(0, 1, 1, 16'h9000, 16'h9000, 2'd0);
        chk("ovr_pre", 32'(overrun), 32'h0);
        prev = left; upd = 0; first_upd = 0;
        @(negedge clk) frame_strobe = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (left !== prev) begin
                upd++;
                if (first_upd == 0) first_upd = c;
                prev = left;
            end
            @(negedge clk);
            frame_strobe = (c == 2);
            if (c == 5) src_left[15:0] = 16'h7000;
        end
        chk("ovr_flag",    32'(overrun),   32'h1);
        chk("ovr_updates", 32'(upd),       32'd1);
        chk("latency",     32'(first_upd), 32'd9);
        chk("ovr_left",    32'(left),      32'h9000);
        chk("ovr_busy",    32'(busy),      32'h0);

        // Reset in the middle of accumulation
        set_src(0, 1, 1, 16'h5000, 16'h3000, 2'd0);
        set_src(2, 1, 0, 16'h0000, 16'h0000, 2'd0);
        @(negedge clk) frame_strobe = 1'b1;
        @(negedge clk) frame_strobe = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (src_ready != 4'd0) seen = 1'b1;
        end
        chk("midacc_grab_seen", 32'(seen), 32'd1);
        @(negedge clk) arst = 1'b1;
        @(negedge clk) arst = 1'b0;
        @(negedge clk);
        chk("mid_rst_left",     32'(left),      32'h8000);
        chk("mid_rst_right",    32'(right),     32'h8000);
        chk("mid_rst_busy",     32'(busy),      32'h0);
        chk("mid_rst_ready",    32'(src_ready), 32'h0);
        chk("mid_rst_underrun", 32'(underrun),  32'h0);
        chk("mid_rst_overrun",  32'(overrun),   32'h0);
        repeat (10) @(negedge clk);
        chk("mid_rst_no_partial", 32'(left), 32'h8000);
        set_src(2, 0, 0, 16'h0000, 16'h0000, 2'd0);
        run_frame(0, rdy, rcyc);
        chk("post_rst_left",  32'(left),  32'h5000);
        chk("post_rst_right", 32'(right), 32'h3000);

        // All sources disabled gives midscale
        set_src(0, 0, 1, 16'hFFFF, 16'hFFFF, 2'd0);
        run_frame(0, rdy, rcyc);
        chk("all_off_left",  32'(left),  32'h8000);
        chk("all_off_right", 32'(right), 32'h8000);
        chk("all_off_ready", 32'(rdy),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_frame_mixer.md
Name: i2s_frame_mixer

Overview:
- Per-frame sample scheduler and mixer placed in front of the PCM5102 I2S transmitter.
- On each audio frame tick (the DAC's clk_strobe/lrck frame signal) it pulls one stereo sample from each enabled source over a valid/ready handshake.
- It mixes the samples with per-source attenuation and saturation, then presents stable left/right words to the DAC.
- Sources that are not ready (underrun) are counted as silence and flagged.

Parameters:
- NUM_SRC, 4, number of requesting sources (1..8)
- DAC_WIDTH, 16, sample width in unsigned offset-binary, as the DAC expects
- ATT_BITS, 2, per-source attenuation field width (right shift of 0..2^ATT_BITS-1)

Ports:
- clk  in  1  system clock
- arst  in  1  reset, asynchronous, active-high
- frame_strobe  in  1  DAC frame signal (clk_strobe); treated as asynchronous
- src_en  in  NUM_SRC  per-source enable
- src_att  in  NUM_SRC*ATT_BITS  per-source attenuation shift; source i occupies bits [i*ATT_BITS +: ATT_BITS]
- src_valid  in  NUM_SRC  source has a sample pair available
- src_ready  out  NUM_SRC  one-cycle grab pulse per source
- src_left  in  NUM_SRC*DAC_WIDTH  left sample, packed per source
- src_right  in  NUM_SRC*DAC_WIDTH  right sample, packed per source
- underrun_clr  in  1  clears all sticky underrun flags
- left  out  DAC_WIDTH  mixed left word to the DAC
- right  out  DAC_WIDTH  mixed right word to the DAC
- underrun  out  NUM_SRC  sticky per-source underrun flags
- overrun  out  1  sticky flag: tick arrived while busy; cleared only by reset
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: left = right = 1<<(DAC_WIDTH-1) (midscale silence); src_ready = 0; underrun = 0; overrun = 0; busy = 0; FSM = IDLE; sync flops = 0.
- Tick generation:
  - frame_strobe passes through a 2-FF synchroniser, then a rising-edge detector.
  - tick is a 1-cycle pulse on the 3rd clk after the rising edge.
  - The rising edge is chosen because the DAC captures left/right on the falling edge, which leaves half a frame of settle time.
- FSM states: IDLE -> GRAB -> ACC -> SAT -> IDLE.
- IDLE:
  - On tick, go to GRAB.
  - Clear accumulators acc_l and acc_r. Each is signed, DAC_WIDTH+clog2(NUM_SRC)+1 bits wide.
- GRAB (1 cycle):
  - src_ready[i] = src_en[i] & src_valid[i].
  - For every source with ready, capture left/right into internal holding registers.
  - For an enabled source with valid=0: hold midscale (zero contribution) and set underrun[i].
  - For a disabled source: hold midscale; underrun is not set.
- ACC (NUM_SRC cycles, index k = 0..NUM_SRC-1):
  - Convert held sample k to signed by inverting its MSB.
  - Arithmetic-shift right by src_att[k]; the att value is sampled in GRAB.
  - Sign-extend and add into acc_l and acc_r.
- SAT (1 cycle):
  - Clamp each accumulator to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1].
  - Invert the MSB back to unsigned and register into left/right.
  - left and right change only in this cycle.
- Latency: rising edge of frame_strobe -> left/right updated = 3 + 1 + NUM_SRC + 1 clk.
- Source handshake rule: src_ready is asserted only in GRAB, never for a disabled source, and at most once per frame.
- Simultaneous events:
  - tick while busy: tick is dropped, overrun set, current mix completes.
  - underrun_clr in the same cycle as a new underrun: set wins.
- Reset mid-operation: async return to IDLE with all outputs at their reset values. No partial mix is ever presented.
- All sources disabled: output is midscale.
- Wrap-around: the accumulator cannot overflow, because its width covers NUM_SRC full-scale values.

Decomposition:
- Shared package i2s_pkg holds:
  - MIDSCALE constant
  - FSM state enum (IDLE/GRAB/ACC/SAT)
  - function for offset-binary to signed conversion (MSB flip)
  - saturate function parameterised on width
- One natural sub-module: i2s_strobe_sync (2-FF synchroniser plus rising-edge pulse), reusable by other lrck consumers.

Test Plan:
- Single source: src0 en, valid, 0xC000/0x4000, att 0; others disabled.
  - Required after tick: left = 0xC000, right = 0x4000; src_ready = 0b0001 for exactly 1 cycle.
- Positive saturation: src0 and src1 both 0xC000, att 0.
  - Signed sum is 0x8000, which exceeds the positive limit. Required: left = 0xFFFF.
  - Same test with both at 0x0000: required left = 0x0000.
- Attenuation: src0 = 0xC000, att = 1.
  - Required: left = 0xA000.
  - Add src1 = 0x2000, att = 0; required: left = 0x4000.
- Underrun: src2 enabled, valid = 0.
  - Required: underrun = 0b0100, contribution = midscale, src_ready[2] = 0.
  - underrun_clr -> 0.
  - Assert underrun_clr on the next GRAB with src2 still invalid: flag remains 1.
- Overrun and latency: pulse frame_strobe twice, 2 clk apart.
  - Required: overrun = 1; exactly one output update; that update lands 3 + 1 + NUM_SRC + 1 = 9 clks after the first rising edge (NUM_SRC = 4).
- Reset mid-ACC: assert arst during ACC.
  - Required: left = right = 0x8000, busy = 0, src_ready = 0, flags = 0.
  - Next tick after reset mixes normally.
